accum_store_ctrl: RTL and testbench

Drain stage directly downstream of the accumulation buffer's store read port. After the buffer is switched, it walks a programmed address range, reads BATCH-wide RES_W partial sums, and optionally applies ReLU. It then rescales each lane to DATA_W with a rounding arithmetic right shift and saturation. Results leave on a valid/ready stream toward the output DMA, with a small credit-tracked skid FIFO that absorbs the RAM read latency under backpressure.

---
 rtl/accum_store_ctrl_pkg.sv | 54 +++++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/accum_store_ctrl.sv | 159 +++++++++++++++
 tb/tb_accum_store_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_store_ctrl_pkg.sv
// rtl/accum_store_ctrl_pkg.sv - shared widths, FSM encoding and lane rescale helper
//
// Purpose: result/data widths, bit-width helper, store-drain FSM states and
// the per-lane rescale function (relu, round, arithmetic shift, saturate)
// shared by the store paths.
package accum_store_ctrl_pkg;

    localparam int RES_W  = 16;
    localparam int DATA_W = 8;

    // Address width for an n-entry buffer; never narrower than one bit.
    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } store_state_t;

    // Saturation bounds expressed in the RES_W+1 rounding domain.
    localparam logic signed [RES_W:0] SAT_MAX = (RES_W+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [RES_W:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [DATA_W-1:0] rescale_lane(
        input logic [RES_W-1:0] x,
        input logic [4:0]       shift,
        input logic             relu_en
    );
        logic signed [RES_W:0] r;
        logic signed [RES_W:0] rnd;
        logic signed [RES_W:0] y;
        r = $signed({x[RES_W-1], x});
        if (relu_en && x[RES_W-1]) begin
            r = '0;
        end
        // Half an LSB of the output scale gives round-half-up after the shift.
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = (RES_W+1)'(1) << (shift - 5'd1);
        end
        r = r + rnd;
        y = r >>> shift;
        if (y > SAT_MAX) begin
            y = SAT_MAX;
        end else if (y < SAT_MIN) begin
            y = SAT_MIN;
        end
        return y[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
//
// Purpose: small skid buffer; rd_data always presents the head entry.
// Ports: clk, rst (sync, active-low), wr_en/wr_data push, rd_en pop,
//        rd_data head entry, count occupancy, empty flag.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/accum_store_ctrl.sv
// rtl/accum_store_ctrl.sv - accumulation buffer drain: read, rescale, stream out
//
// Purpose: walks base_addr..base_addr+len-1 (mod DEPTH) on the store read
// port, rescales each BATCH-lane entry to DATA_W and streams it out with
// out_last on the final beat. A credit count (reads in flight + FIFO
// occupancy) keeps the skid FIFO from overflowing under backpressure.
// Ports: clk, rst (sync, active-low); start/base_addr/len/shift/relu_en job
//        launch; busy, done status; sv_rd_addr/sv_rd_data store port;
//        out_valid/out_ready/out_data/out_last output stream.
module accum_store_ctrl
    import accum_store_ctrl_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int BATCH      = 32,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int ADDR_W    = bw(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [ADDR_W:0]           len,
    input  logic [4:0]                shift,
    input  logic                      relu_en,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         sv_rd_addr,
    input  logic [BATCH*RES_W-1:0]    sv_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BATCH*DATA_W-1:0]   out_data,
    output logic                      out_last
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FW    = BATCH * DATA_W + 1;

    store_state_t state;
    store_state_t state_nxt;

    logic [ADDR_W:0]          remaining;
    logic [4:0]               shift_r;
    logic                     relu_r;
    logic [CNT_W-1:0]         outstanding;
    logic [RD_LAT-1:0]        vld_sr;
    logic [RD_LAT-1:0]        last_sr;

    logic                     issue;
    logic                     emerge;
    logic                     pop;
    logic [BATCH*DATA_W-1:0]  proc;
    logic [FW-1:0]            fifo_rd;
    logic [CNT_W-1:0]         fifo_count;
    logic                     fifo_empty;

    // Uses the registered FIFO count, so a pop in this cycle frees its slot
    // only from the next cycle on.
    assign issue  = (state == ST_RUN) &&
                    (({1'b0, outstanding} + {1'b0, fifo_count}) < (CNT_W+1)'(FIFO_DEPTH));
    assign emerge = vld_sr[RD_LAT-1];
    assign pop    = out_valid && out_ready;

    assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign out_valid = !fifo_empty;
    // Gated so a flushed FIFO never exposes stale RAM contents.
    assign out_data  = fifo_empty ? '0 : fifo_rd[FW-2:0];
    assign out_last  = !fifo_empty && fifo_rd[FW-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && remaining == (ADDR_W+1)'(1)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The tagged beat is the last read's data, so once it leaves
                // the FIFO is empty and nothing remains in flight.
                if (pop && out_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sv_rd_addr  <= '0;
            remaining   <= '0;
            shift_r     <= '0;
            relu_r      <= 1'b0;
            outstanding <= '0;
            vld_sr      <= '0;
            last_sr     <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                sv_rd_addr <= base_addr;
                remaining  <= len;
                shift_r    <= shift;
                relu_r     <= relu_en;
            end
            if (issue) begin
                sv_rd_addr <= (sv_rd_addr == ADDR_W'(DEPTH - 1)) ? '0 : sv_rd_addr + 1'b1;
                remaining  <= remaining - 1'b1;
            end
            vld_sr[0]  <= issue;
            last_sr[0] <= issue && (remaining == (ADDR_W+1)'(1));
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(emerge);
        end
    end

    always_comb begin
        proc = '0;
        for (int l = 0; l < BATCH; l++) begin
            proc[l*DATA_W +: DATA_W] = rescale_lane(sv_rd_data[l*RES_W +: RES_W], shift_r, relu_r);
        end
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (emerge),
        .wr_data ({last_sr[RD_LAT-1], proc}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_accum_store_ctrl.sv
// tb/tb_accum_store_ctrl.sv - directed scoreboard bench for accum_store_ctrl
module tb_accum_store_ctrl;
    import accum_store_ctrl_pkg::*;

    localparam int DEPTH      = 256;
    localparam int BATCH      = 32;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 8;
    localparam int DW         = BATCH * DATA_W;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic [ADDR_W-1:0]       base_addr = '0;
    logic [ADDR_W:0]         len = '0;
    logic [4:0]              shift = '0;
    logic                    relu_en = 1'b0;
    logic                    busy;
    logic                    done;
    logic [ADDR_W-1:0]       sv_rd_addr;
    logic [BATCH*RES_W-1:0]  sv_rd_data;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [DW-1:0]           out_data;
    logic                    out_last;

    accum_store_ctrl #(
        .DEPTH      (DEPTH),
        .BATCH      (BATCH),
        .RD_LAT     (RD_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .len        (len),
        .shift      (shift),
        .relu_en    (relu_en),
        .busy       (busy),
        .done       (done),
        .sv_rd_addr (sv_rd_addr),
        .sv_rd_data (sv_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- buffer model ----------------
    int mode = 0;

    function automatic int lane_val(input int addr, input int lane, input int md);
        if (md == 1) begin
            case (lane)
                0:       return 24;
                1:       return -24;
                2:       return 7;
                3:       return (1 << (RES_W - 1)) - 1;
                default: return ((addr * 37 + lane * 101) % 4000) - 2000;
            endcase
        end else if (md == 2) begin
            return addr - 128;
        end
        return addr;
    endfunction

    function automatic logic [BATCH*RES_W-1:0] mk_data(input int addr, input int md);
        logic [BATCH*RES_W-1:0] d;
        int v;
        d = '0;
        for (int l = 0; l < BATCH; l++) begin
            v = lane_val(addr, l, md);
            d[l*RES_W +: RES_W] = v[RES_W-1:0];
        end
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] ref_lane(input int x, input int sh, input bit rl);
        int v;
        int hi;
        int lo;
        hi = (1 << (DATA_W - 1)) - 1;
        lo = -(1 << (DATA_W - 1));
        v = x;
        if (rl && v < 0) v = 0;
        if (sh > 0) v = v + (1 << (sh - 1));
        v = v >>> sh;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DW-1:0] exp_data(input int addr, input int sh, input bit rl, input int md);
        logic [DW-1:0] d;
        d = '0;
        for (int l = 0; l < BATCH; l++) begin
            d[l*DATA_W +: DATA_W] = ref_lane(lane_val(addr, l, md), sh, rl);
        end
        return d;
    endfunction

    logic [ADDR_W-1:0] apipe [RD_LAT];
    always @(posedge clk) begin
        apipe[0] <= sv_rd_addr;
        for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign sv_rd_data = mk_data(int'(apipe[RD_LAT-1]), mode);

    // ---------------- ready driver ----------------
    bit force_low = 1'b1;
    bit toggle    = 1'b0;
    int ph        = 0;
    always @(posedge clk) begin
        #2;
        if (force_low)   out_ready = 1'b0;
        else if (toggle) out_ready = (ph == 0);
        else             out_ready = 1'b1;
        ph = (ph + 1) % 4;
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;
    beat_t exp_q[$];

    int            beats = 0;
    int            first_valid_cyc = -1;
    int            last_hs_cyc = -1;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            start_cyc = 0;
    int            d0 = 0;
    logic [DW-1:0] first_data = '0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          prev_rst = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            if (prev_stall && prev_rst) begin
                total++;
                assert (out_valid === 1'b1 && out_data === prev_data && out_last === prev_last)
                else begin
                    bad++;
                    $error("FAIL stall_hold observed valid=%0b last=%0b data=%0h expected valid=1 last=%0b data=%0h",
                           out_valid, out_last, out_data, prev_last, prev_data);
                end
            end
            if (busy) begin
                total++;
                assert (int'(dut.outstanding) + int'(dut.fifo_count) <= FIFO_DEPTH)
                else begin
                    bad++;
                    $error("FAIL credit observed=%0d expected<=%0d",
                           int'(dut.outstanding) + int'(dut.fifo_count), FIFO_DEPTH);
                end
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                total++;
                assert (exp_q.size() > 0)
                else begin
                    bad++;
                    $error("FAIL unexpected_beat observed data=%0h expected no beat", out_data);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    total++;
                    assert (out_data === e.data && out_last === e.last)
                    else begin
                        bad++;
                        $error("FAIL beat%0d observed last=%0b data=%0h expected last=%0b data=%0h",
                               beats, out_last, out_data, e.last, e.data);
                    end
                end
                if (beats == 0) first_data = out_data;
                if (out_last) last_hs_cyc = cyc;
                beats++;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_rst   = rst;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_last"}, int'(out_last), 0);
        chk({tag, "_addr"}, int'(sv_rd_addr), 0);
        chk({tag, "_data_zero"}, int'(out_data == '0), 1);
    endtask

    task automatic launch(input int b, input int n, input int sh, input bit rl, input int md);
        beat_t e;
        mode = md;
        for (int i = 0; i < n; i++) begin
            e.data = exp_data((b + i) % DEPTH, sh, rl, md);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        beats = 0;
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        d0 = done_cnt;
        base_addr = ADDR_W'(b);
        len       = (ADDR_W+1)'(n);
        shift     = 5'(sh);
        relu_en   = rl;
        start     = 1'b1;
        start_cyc = cyc;
        step(1);
        start     = 1'b0;
        base_addr = '1;
        len       = '1;
        shift     = '1;
        relu_en   = ~rl;
        if (n > 0) begin
            chk("busy_at_1", int'(busy), 1);
            chk("addr_at_1", int'(sv_rd_addr), b % DEPTH);
        end else begin
            chk("len0_done_at_1", int'(done), 1);
            chk("len0_busy_at_1", int'(busy), 0);
        end
    endtask

    task automatic wait_done(input bit check_lat);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 600) begin
            step(1);
            k++;
        end
        chk("job_done_pulses", done_cnt - d0, 1);
        chk("queue_drained", exp_q.size(), 0);
        chk("done_after_last", done_cyc - last_hs_cyc, 1);
        if (check_lat) chk("first_valid_lat", first_valid_cyc - start_cyc, RD_LAT + 2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        force_low = 1'b1;
        step(3);
        check_reset_outputs("reset");
        rst = 1'b1;
        force_low = 1'b0;
        step(2);

        // basic: lanes = address, identity rescale
        launch(0, 4, 0, 1'b0, 0);
        wait_done(1'b1);
        chk("basic_beats", beats, 4);
        step(2);

        // address wrap
        launch(DEPTH - 2, 4, 0, 1'b0, 2);
        step(1);
        chk("wrap_addr1", int'(sv_rd_addr), DEPTH - 1);
        step(1);
        chk("wrap_addr2", int'(sv_rd_addr), 0);
        step(1);
        chk("wrap_addr3", int'(sv_rd_addr), 1);
        wait_done(1'b1);
        step(2);

        // rounding shift and saturation
        launch(20, 3, 4, 1'b0, 1);
        wait_done(1'b1);
        chk("rescale_l0", int'(first_data[0*DATA_W +: DATA_W]), 2);
        chk("rescale_l1", int'(first_data[1*DATA_W +: DATA_W]), 255);
        chk("rescale_l2", int'(first_data[2*DATA_W +: DATA_W]), 0);
        chk("rescale_l3", int'(first_data[3*DATA_W +: DATA_W]), 127);
        step(2);

        launch(20, 3, 4, 1'b1, 1);
        wait_done(1'b1);
        chk("relu_l0", int'(first_data[0*DATA_W +: DATA_W]), 2);
        chk("relu_l1", int'(first_data[1*DATA_W +: DATA_W]), 0);
        chk("relu_l2", int'(first_data[2*DATA_W +: DATA_W]), 0);
        chk("relu_l3", int'(first_data[3*DATA_W +: DATA_W]), 127);
        step(2);

        // backpressure: 1 on, 3 off
        toggle = 1'b1;
        launch(100, 16, 0, 1'b0, 0);
        wait_done(1'b0);
        chk("toggle_beats", beats, 16);
        toggle = 1'b0;
        step(2);

        // len = 0
        launch(5, 0, 0, 1'b0, 0);
        step(6);
        chk("len0_beats", beats, 0);
        chk("len0_no_valid", first_valid_cyc, -1);
        chk("len0_one_done", done_cnt - d0, 1);
        step(2);

        // start while busy is ignored
        launch(10, 4, 0, 1'b0, 0);
        base_addr = 8'd50;
        len       = 9'd8;
        start     = 1'b1;
        step(1);
        start     = 1'b0;
        wait_done(1'b1);
        step(20);
        chk("busy_start_beats", beats, 4);
        chk("busy_start_one_done", done_cnt - d0, 1);
        chk("busy_start_idle", int'(busy), 0);

        // reset in the middle of a job
        launch(30, 16, 0, 1'b0, 0);
        for (int k = 0; k < 200; k++) begin
            if (beats == 4 && out_valid) break;
            step(1);
        end
        chk("reached_beat5", beats, 4);
        rst = 1'b0;
        force_low = 1'b1;
        step(1);
        rst = 1'b1;
        check_reset_outputs("midreset");
        exp_q.delete();
        d0 = done_cnt;
        force_low = 1'b0;
        step(15);
        chk("midreset_no_done", done_cnt - d0, 0);
        chk("midreset_no_valid", int'(out_valid), 0);

        launch(60, 5, 0, 1'b0, 0);
        wait_done(1'b1);
        chk("post_reset_beats", beats, 5);
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
